// File: rtl/nibbler_pkg.sv
// Shared types and decode helpers for the nibble processor sequencer.
package nibbler_pkg;

    typedef enum logic [3:0] {
        OP_JC   = 4'h0,
        OP_JNC  = 4'h1,
        OP_CMPI = 4'h2,
        OP_CMPM = 4'h3,
        OP_LIT  = 4'h4,
        OP_IN   = 4'h5,
        OP_LD   = 4'h6,
        OP_ST   = 4'h7,
        OP_JZ   = 4'h8,
        OP_JNZ  = 4'h9,
        OP_ADDI = 4'hA,
        OP_ADDM = 4'hB,
        OP_JMP  = 4'hC,
        OP_OUT  = 4'hD,
        OP_NORI = 4'hE,
        OP_NORM = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_t;

    localparam int CTRL_INC_PC    = 15;
    localparam int CTRL_LOAD_PC_N = 14;

    // Opcodes whose execute cycle latches the ALU carry/zero into the flags.
    function automatic logic alu_flag_ops(input logic [3:0] op);
        logic hit;
        case (opcode_t'(op))
            OP_CMPI, OP_CMPM, OP_ADDI, OP_ADDM, OP_NORI, OP_NORM: hit = 1'b1;
            default:                                              hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/nibbler_pc.sv
// Program counter register with hold / increment / load select.
module nibbler_pc
    import nibbler_pkg::*;
#(
    parameter int PC_W = 12
) (
    input  logic            clk,
    input  logic            reset_n,
    input  pc_sel_t         sel,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_next
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_next_s;

    // Next-pc select; increment wraps naturally at the address width.
    always_comb begin
        pc_next_s = pc_r;
        case (sel)
            PC_HOLD: pc_next_s = pc_r;
            PC_INC:  pc_next_s = pc_r + PC_ONE;
            PC_LOAD: pc_next_s = load_val;
            default: pc_next_s = pc_r;
        endcase
    end

    // PC storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r <= {PC_W{1'b0}};
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign pc      = pc_r;
    assign pc_next = pc_next_s;

endmodule

// File: rtl/nibbler_sequencer.sv
// Fetch/execute sequencer: FSM, instruction register and C/Z flags.
// Optional breakpoint logic is enabled by defining NIBBLER_SEQ_BREAKPOINT_EN.
module nibbler_sequencer
    import nibbler_pkg::*;
#(
    parameter int PC_W    = 12,
    parameter int INSTR_W = 8,
    parameter int CTRL_W  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic               step,
    input  logic [INSTR_W-1:0] prog_byte,
    output logic [PC_W-1:0]    pc,
    output logic [6:0]         ctrl_addr,
    input  logic [CTRL_W-1:0]  ctrl_word,
    input  logic               alu_c,
    input  logic               alu_z,
    output logic [3:0]         operand,
    output logic [PC_W-1:0]    mem_addr,
    output logic               phase,
    output logic               halted
`ifdef NIBBLER_SEQ_BREAKPOINT_EN
    ,
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_addr,
    output logic               bp_hit
`endif
);

    seq_state_t         state_r;
    seq_state_t         next_state_s;
    logic [INSTR_W-1:0] ir_r;
    logic               c_flag_r;
    logic               z_flag_r;
    pc_sel_t            pc_sel_s;
    logic               flag_wr_s;
    logic               bp_stop_s;
    logic [PC_W-1:0]    pc_s;
    logic [PC_W-1:0]    pc_next_s;
    logic [PC_W-1:0]    mem_addr_s;
    logic               unused_ctrl_s;

    assign mem_addr_s    = PC_W'({ir_r[3:0], prog_byte});
    assign unused_ctrl_s = ^ctrl_word;

    nibbler_pc #(
        .PC_W (PC_W)
    ) u_pc (
        .clk      (clk),
        .reset_n  (reset_n),
        .sel      (pc_sel_s),
        .load_val (mem_addr_s),
        .pc       (pc_s),
        .pc_next  (pc_next_s)
    );

`ifdef NIBBLER_SEQ_BREAKPOINT_EN
    logic bp_hit_r;

    assign bp_stop_s = (state_r == EXEC) && bp_en && (pc_next_s == bp_addr);

    // Sticky breakpoint indication, cleared when execution resumes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bp_hit_r <= 1'b0;
        end else if ((state_r == IDLE) && (next_state_s == FETCH)) begin
            bp_hit_r <= 1'b0;
        end else if (bp_stop_s) begin
            bp_hit_r <= 1'b1;
        end else begin
            bp_hit_r <= bp_hit_r;
        end
    end

    assign bp_hit = bp_hit_r;
`else
    assign bp_stop_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; step only matters while idle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (run || step) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: next_state_s = EXEC;
            EXEC: begin
                if (run && !bp_stop_s) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Per-state outputs and PC/flag controls; LOAD_PC_N low outranks INC_PC.
    always_comb begin
        pc_sel_s  = PC_HOLD;
        flag_wr_s = 1'b0;
        phase     = 1'b0;
        halted    = 1'b0;
        case (state_r)
            IDLE: begin
                halted = 1'b1;
            end
            FETCH: begin
                pc_sel_s = PC_INC;
            end
            EXEC: begin
                phase     = 1'b1;
                flag_wr_s = alu_flag_ops(ir_r[INSTR_W-1:INSTR_W-4]);
                if (!ctrl_word[CTRL_LOAD_PC_N]) begin
                    pc_sel_s = PC_LOAD;
                end else if (ctrl_word[CTRL_INC_PC]) begin
                    pc_sel_s = PC_INC;
                end else begin
                    pc_sel_s = PC_HOLD;
                end
            end
            default: begin
                halted = 1'b1;
            end
        endcase
    end

    // Instruction register, loaded at the end of FETCH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_r <= {INSTR_W{1'b0}};
        end else if (state_r == FETCH) begin
            ir_r <= prog_byte;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Carry/zero flags, written only by ALU-flag opcodes at the end of EXEC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_flag_r <= 1'b0;
            z_flag_r <= 1'b0;
        end else if (flag_wr_s) begin
            c_flag_r <= alu_c;
            z_flag_r <= alu_z;
        end else begin
            c_flag_r <= c_flag_r;
            z_flag_r <= z_flag_r;
        end
    end

    assign pc        = pc_s;
    assign ctrl_addr = {ir_r[INSTR_W-1:INSTR_W-4], ~c_flag_r, ~z_flag_r, phase};
    assign operand   = ir_r[3:0];
    assign mem_addr  = mem_addr_s;

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Self-checking bench for nibbler_sequencer: directed scenarios plus random
// programs checked cycle by cycle against an instruction-level model.
module tb_nibbler_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic        step;
    logic [7:0]  prog_byte;
    logic [11:0] pc;
    logic [6:0]  ctrl_addr;
    logic [15:0] ctrl_word;
    logic        alu_c;
    logic        alu_z;
    logic [3:0]  operand;
    logic [11:0] mem_addr;
    logic        phase;
    logic        halted;
`ifdef NIBBLER_SEQ_BREAKPOINT_EN
    logic        bp_en;
    logic [11:0] bp_addr;
    logic        bp_hit;
`endif

    logic [7:0]  prog_mem [4096];
    logic [15:0] ctrl_mem [128];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model state: stage 0 = halted, 1 = fetching, 2 = executing
    int m_pc;
    int m_ir;
    bit m_c;
    bit m_z;
    int m_st;
    bit m_bp;

    always #5 clk = ~clk;

    assign prog_byte = prog_mem[pc];
    assign ctrl_word = ctrl_mem[ctrl_addr];

    nibbler_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .step      (step),
        .prog_byte (prog_byte),
        .pc        (pc),
        .ctrl_addr (ctrl_addr),
        .ctrl_word (ctrl_word),
        .alu_c     (alu_c),
        .alu_z     (alu_z),
        .operand   (operand),
        .mem_addr  (mem_addr),
        .phase     (phase),
        .halted    (halted)
`ifdef NIBBLER_SEQ_BREAKPOINT_EN
        ,
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .bp_hit    (bp_hit)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_caddr(input bit exec_phase);
        return (m_ir / 16) * 8 + (m_c ? 0 : 4) + (m_z ? 0 : 2) + (exec_phase ? 1 : 0);
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_c = 1'b0; m_z = 1'b0; m_st = 0; m_bp = 1'b0;
    endtask

    // One clock edge of the instruction-level model, from bench inputs only.
    task automatic model_step();
        logic [15:0] cw;
        int npc;
        int op;
        bit hit;
        hit = 1'b0;
        if (!reset_n) begin
            model_reset();
        end else if (m_st == 0) begin
            if (run || step) begin
                m_st = 1;
                m_bp = 1'b0;
            end
        end else if (m_st == 1) begin
            m_ir = int'(prog_mem[m_pc]);
            m_pc = (m_pc + 1) % 4096;
            m_st = 2;
        end else begin
            cw = ctrl_mem[exp_caddr(1'b1)];
            if (!cw[14])     npc = (m_ir % 16) * 256 + int'(prog_mem[m_pc]);
            else if (cw[15]) npc = (m_pc + 1) % 4096;
            else             npc = m_pc;
            op = m_ir / 16;
            if (op == 2 || op == 3 || op == 10 || op == 11 || op == 14 || op == 15) begin
                m_c = alu_c;
                m_z = alu_z;
            end
`ifdef NIBBLER_SEQ_BREAKPOINT_EN
            hit = bp_en && (npc == int'(bp_addr));
`endif
            m_pc = npc;
            if (hit) m_bp = 1'b1;
            m_st = (run && !hit) ? 1 : 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic fill_base();
        for (int i = 0; i < 4096; i++) prog_mem[i] = 8'h40;
        for (int i = 0; i < 128; i++) ctrl_mem[i] = 16'h4000;
    endtask

    task automatic set_op_ctrl(input int op, input logic [15:0] w);
        for (int i = 0; i < 8; i++) ctrl_mem[op * 8 + i] = w;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run = 1'b0;
        step = 1'b0;
`ifdef NIBBLER_SEQ_BREAKPOINT_EN
        bp_en = 1'b0;
        bp_addr = 12'h000;
`endif
        model_reset();
        tick();
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", 32'(pc), 32'(m_pc));
            check("ctrl_addr", 32'(ctrl_addr), 32'(exp_caddr(m_st == 2)));
            check("operand", 32'(operand), 32'(m_ir % 16));
            check("phase", 32'(phase), (m_st == 2) ? 32'd1 : 32'd0);
            check("halted", 32'(halted), (m_st == 0) ? 32'd1 : 32'd0);
            if (m_st == 2)
                check("mem_addr", 32'(mem_addr), 32'((m_ir % 16) * 256 + int'(prog_mem[m_pc])));
`ifdef NIBBLER_SEQ_BREAKPOINT_EN
            check("bp_hit", 32'(bp_hit), 32'(m_bp));
`endif
        end
    end

    initial begin
        int exp_pc [6];
        int exp_ph [6];
        int busy;
        reset_n = 1'b1;
        run = 1'b0;
        step = 1'b0;
        alu_c = 1'b0;
        alu_z = 1'b0;
`ifdef NIBBLER_SEQ_BREAKPOINT_EN
        bp_en = 1'b0;
        bp_addr = 12'h000;
`endif
        fill_base();
        #1;
        reset_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        tick();
        check("rst_pc", 32'(pc), 32'h000);
        check("rst_ctrl_addr", 32'(ctrl_addr), 32'h06);
        check("rst_halted", 32'(halted), 32'd1);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_operand", 32'(operand), 32'd0);

        // LIT 5 ; JMP 0x000 loop
        prog_mem[0] = 8'h45; prog_mem[1] = 8'hC0; prog_mem[2] = 8'h00;
        set_op_ctrl(12, 16'h0000);
        reset_n = 1'b1;
        run = 1'b1;
        exp_pc = '{0, 1, 1, 2, 0, 1};
        exp_ph = '{0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 6; i++) begin
            tick();
            check("loop_pc", 32'(pc), 32'(exp_pc[i]));
            check("loop_phase", 32'(phase), 32'(exp_ph[i]));
            if (i == 1) check("loop_lit_caddr", 32'(ctrl_addr), 32'h27);
            if (i == 3) check("loop_jmp_op", 32'(ctrl_addr[6:3]), 32'hC);
        end

        // ADDI sets C=1 Z=0, then JC 0x034 taken
        do_reset();
        fill_base();
        prog_mem[0] = 8'hA7; prog_mem[1] = 8'h00; prog_mem[2] = 8'h34;
        set_op_ctrl(0, 16'hC000);
        ctrl_mem[1] = 16'h0000;
        ctrl_mem[3] = 16'h0000;
        reset_n = 1'b1;
        run = 1'b1;
        alu_c = 1'b1;
        alu_z = 1'b0;
        tick(); tick(); tick();
        check("addi_flags", 32'(ctrl_addr), 32'h52);
        check("addi_pc", 32'(pc), 32'h001);
        tick();
        check("jc_caddr", 32'(ctrl_addr), 32'h03);
        check("jc_mem_addr", 32'(mem_addr), 32'h034);
        tick();
        check("jc_pc", 32'(pc), 32'h034);

        // JNZ not taken skips its address byte, flags untouched
        do_reset();
        fill_base();
        prog_mem[0] = 8'h95; prog_mem[1] = 8'h12;
        set_op_ctrl(9, 16'hF837);
        reset_n = 1'b1;
        run = 1'b1;
        alu_c = 1'b1;
        alu_z = 1'b1;
        tick(); tick(); tick();
        check("jnz_pc", 32'(pc), 32'h002);
        check("jnz_flags", 32'(ctrl_addr), 32'h4E);

        // fetch at 0xFFF wraps to 0x000
        do_reset();
        fill_base();
        prog_mem[0] = 8'hCF; prog_mem[1] = 8'hFF;
        set_op_ctrl(12, 16'h0000);
        reset_n = 1'b1;
        run = 1'b1;
        tick(); tick(); tick();
        check("wrap_pre", 32'(pc), 32'hFFF);
        tick();
        check("wrap_pc", 32'(pc), 32'h000);
        check("wrap_phase", 32'(phase), 32'd1);

        // two single-step pulses while halted
        do_reset();
        fill_base();
        reset_n = 1'b1;
        busy = 0;
        for (int i = 0; i < 10; i++) begin
            step = (i == 0 || i == 5);
            tick();
            if (!halted) busy++;
            if (i == 3) begin
                check("step_halted_gap", 32'(halted), 32'd1);
                check("step_pc_gap", 32'(pc), 32'h001);
            end
        end
        check("step_busy", 32'(busy), 32'd4);
        check("step_pc_end", 32'(pc), 32'h002);

        // reset during EXEC of ADDM aborts with no flag update
        do_reset();
        fill_base();
        prog_mem[0] = 8'hB1; prog_mem[1] = 8'h23;
        set_op_ctrl(11, 16'hC000);
        reset_n = 1'b1;
        run = 1'b1;
        alu_c = 1'b1;
        alu_z = 1'b1;
        tick(); tick();
        check("addm_in_exec", 32'(phase), 32'd1);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("abort_pc", 32'(pc), 32'h000);
        check("abort_caddr", 32'(ctrl_addr), 32'h06);
        check("abort_halted", 32'(halted), 32'd1);
        check("abort_operand", 32'(operand), 32'd0);
        tick();
        reset_n = 1'b1;
        run = 1'b0;
        tick();
        check("abort_flags", 32'(ctrl_addr), 32'h06);

`ifdef NIBBLER_SEQ_BREAKPOINT_EN
        // breakpoint at 0x003 halts despite run
        begin
            bit done;
            do_reset();
            fill_base();
            reset_n = 1'b1;
            run = 1'b1;
            bp_en = 1'b1;
            bp_addr = 12'h003;
            done = 1'b0;
            for (int k = 0; k < 30 && !done; k++) begin
                tick();
                if (halted) done = 1'b1;
            end
            check("bp_halted", 32'(done), 32'd1);
            check("bp_pc", 32'(pc), 32'h003);
            check("bp_hit_set", 32'(bp_hit), 32'd1);
            bp_en = 1'b0;
            tick();
            check("bp_hit_clr", 32'(bp_hit), 32'd0);
        end
`endif

        // random programs and control words
        do_reset();
        for (int i = 0; i < 4096; i++) prog_mem[i] = 8'($urandom);
        for (int i = 0; i < 128; i++) ctrl_mem[i] = 16'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if (!reset_n) begin
                reset_n = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                model_reset();
            end
            run = ($urandom_range(0, 3) != 0);
            step = (m_st == 0) && ($urandom_range(0, 2) == 0);
            alu_c = 1'($urandom);
            alu_z = 1'($urandom);
`ifdef NIBBLER_SEQ_BREAKPOINT_EN
            bp_en = ($urandom_range(0, 5) == 0);
            bp_addr = 12'((m_pc + int'($urandom_range(0, 3))) % 4096);
`endif
            tick();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
